// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue
//   Byte-stream front end for spi_master, running on the same clock. The host
//   pushes bytes into a TX FIFO. For each queued byte the block pops it into a
//   holding register that drives spi_tx_byte and pulses spi_start for one
//   cycle. It then waits for spi_done and pushes spi_rx_byte into an RX FIFO,
//   which the host drains. The RX FIFO is first-word-fall-through.
//
// Build option:
//   SPI_QUEUE_GAP_EN - when defined, a GAP state holds the queue for
//                      GAP_CYCLES cycles after every spi_done, so the slave
//                      sees a chip-select deassert time. When undefined, the
//                      GAP state and its counter do not exist.
//
// Ports:
//   clk, rst          system clock; synchronous active-high reset
//   enable            1 = launch transfers from the TX FIFO, 0 = hold them
//   wr_en, wr_data    TX FIFO push (ignored while tx_full)
//   tx_full, tx_count TX FIFO status
//   rd_en, rd_data    RX FIFO pop / head (0 while empty)
//   rx_empty, rx_count RX FIFO status
//   rx_overflow       sticky flag for a received byte dropped on a full RX FIFO
//   ovf_clr           clears rx_overflow (a coincident drop wins)
//   idle              FSM in IDLE and TX FIFO empty
//   spi_start         one-cycle start pulse to the master
//   spi_tx_byte       byte to the master, held for the whole transfer
//   spi_rx_byte, spi_busy, spi_done  master feedback
module spi_xfer_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      tx_full,
  output logic [$clog2(DEPTH):0]    tx_count,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rx_empty,
  output logic [$clog2(DEPTH):0]    rx_count,
  output logic                      rx_overflow,
  input  logic                      ovf_clr,
  output logic                      idle,
  output logic                      spi_start,
  output logic [DATA_WIDTH-1:0]     spi_tx_byte,
  input  logic [DATA_WIDTH-1:0]     spi_rx_byte,
  input  logic                      spi_busy,
  input  logic                      spi_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spi_xfer_queue: DEPTH must be a power of two >= 2");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("spi_xfer_queue: GAP_CYCLES must be >= 0");
  end

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE
`ifdef SPI_QUEUE_GAP_EN
    , GAP
`endif
  } state_t;

  state_t state_q, state_d;
  logic   tx_pop;
  logic   rx_push;

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]         tx_wptr_q, tx_rptr_q;
  logic [CW-1:0]         tx_cnt_q;
  logic                  tx_push;

  assign tx_full  = (tx_cnt_q == CW'(DEPTH));
  assign tx_count = tx_cnt_q;
  assign tx_push  = wr_en & ~tx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
      tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= wr_data;
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]         rx_wptr_q, rx_rptr_q;
  logic [CW-1:0]         rx_cnt_q;
  logic                  rx_full, rx_pop, rx_wr, rx_drop;
  logic                  ovf_q, ovf_d;

  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_count = rx_cnt_q;
  assign rx_pop   = rd_en & ~rx_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // only dropped when nothing is read.
  assign rx_wr    = rx_push & (~rx_full | rx_pop);
  assign rx_drop  = rx_push & rx_full & ~rx_pop;
  assign rd_data  = rx_empty ? '0 : rx_mem[rx_rptr_q];

  // Set has priority over clear so a drop is never lost.
  assign ovf_d       = rx_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  assign rx_overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (rx_wr)  rx_wptr_q <= rx_wptr_q + AW'(1);
      if (rx_pop) rx_rptr_q <= rx_rptr_q + AW'(1);
      rx_cnt_q <= rx_cnt_q + CW'(rx_wr) - CW'(rx_pop);
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wptr_q] <= spi_rx_byte;
  end

  // ---------------- Transfer FSM ----------------
  logic [DATA_WIDTH-1:0] tx_byte_q;

`ifdef SPI_QUEUE_GAP_EN
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
`ifdef SPI_QUEUE_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable && (tx_cnt_q != '0) && !spi_busy) begin
          tx_pop  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (spi_done) begin
          rx_push = 1'b1;
`ifdef SPI_QUEUE_GAP_EN
          if (GAP_CYCLES > 0) begin
            // Counter holds the cycles still to spend in GAP after this one.
            state_d   = GAP;
            gap_cnt_d = GW'(GAP_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef SPI_QUEUE_GAP_EN
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - GW'(1);
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_byte_q <= '0;
`ifdef SPI_QUEUE_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (tx_pop) tx_byte_q <= tx_mem[tx_rptr_q];
`ifdef SPI_QUEUE_GAP_EN
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign spi_start   = (state_q == LAUNCH);
  assign spi_tx_byte = tx_byte_q;
  assign idle        = (state_q == IDLE) && (tx_cnt_q == '0);

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Testbench for spi_xfer_queue: a cycle table covers reset and TX fill, and
// hand-written sequences cover transfer latency, ordering, RX overflow, the
// post-done gap and reset during a transfer. A small master model answers
// each start after MM_LAT cycles with (tx_byte ^ mask).
module tb_spi_xfer_queue;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int GAP = 3;
`ifdef SPI_QUEUE_GAP_EN
  localparam int GAPX = GAP;
`else
  localparam int GAPX = 0;
`endif

  logic          clk, rst, enable, wr_en, rd_en, ovf_clr;
  logic [DW-1:0] wr_data, rd_data, spi_tx_byte, spi_rx_byte;
  logic          tx_full, rx_empty, rx_overflow, idle, spi_start, spi_busy, spi_done;
  logic [3:0]    tx_count, rx_count;

  spi_xfer_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(tx_full), .tx_count(tx_count), .rd_en(rd_en), .rd_data(rd_data),
    .rx_empty(rx_empty), .rx_count(rx_count), .rx_overflow(rx_overflow),
    .ovf_clr(ovf_clr), .idle(idle), .spi_start(spi_start),
    .spi_tx_byte(spi_tx_byte), .spi_rx_byte(spi_rx_byte),
    .spi_busy(spi_busy), .spi_done(spi_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- master model ----------------
  logic [DW-1:0] mm_mask = 8'h00;
  logic [DW-1:0] mm_tx = 8'h00;
  int            mm_lat = 6;
  int            mm_cnt = 0;
  bit            mm_nochk = 1'b0;
  logic [DW-1:0] start_log[$];
  int            start_cyc[$];
  int            done_cyc[$];

  initial begin
    spi_busy = 1'b0; spi_done = 1'b0; spi_rx_byte = '0;
    forever begin
      @(posedge clk); #1;
      spi_done = 1'b0;
      if (mm_cnt > 0) begin
        mm_cnt--;
        if (mm_cnt == 0) begin
          spi_done    = 1'b1;
          spi_busy    = 1'b0;
          spi_rx_byte = mm_tx ^ mm_mask;
          done_cyc.push_back(cyc);
          if (!mm_nochk) chk("tx_byte_hold", 32'(spi_tx_byte), 32'(mm_tx));
        end
      end else if (spi_start) begin
        mm_tx    = spi_tx_byte;
        spi_busy = 1'b1;
        mm_cnt   = mm_lat;
        start_log.push_back(spi_tx_byte);
        start_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    start_log.delete(); start_cyc.delete(); done_cyc.delete();
  endtask

  task automatic wait_idle(input int bound, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!(idle && !spi_busy) && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (k >= bound) begin
      n_vec++; n_bad++;
      $display("FAIL %s: idle not reached, got busy after %0d cycles, expected idle", name, bound);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic write_byte(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [DW-1:0] e);
    chk(name, 32'(rd_data), 32'(e));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic          rst, en, wr;
    logic [DW-1:0] wd;
    logic [3:0]    e_txc;
    logic          e_full;
    logic [3:0]    e_rxc;
    logic          e_rxe, e_idle, e_start;
  } vec_t;

  vec_t vt[14];

  initial begin
    int n;
    logic [DW-1:0] exp_b[$];

    rst = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; ovf_clr = 1'b0;

    for (int i = 0; i < 3; i++) vt[i] = '{1'b1, 1'b0, 1'b1, 8'h11, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 8; k++)
      vt[4+k] = '{1'b0, 1'b0, 1'b1, 8'(8'h10 + k), 4'(k + 1), (k == 7), 4'd0, 1'b1, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b1, 8'h18, 4'd8, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'd8, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};

    // Reset with writes held high, then fill TX past full with enable low.
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst; enable = vt[i].en; wr_en = vt[i].wr; wr_data = vt[i].wd;
      @(negedge clk);
      chk($sformatf("v%0d.tx_count", i), 32'(tx_count), 32'(vt[i].e_txc));
      chk($sformatf("v%0d.tx_full", i), 32'(tx_full), 32'(vt[i].e_full));
      chk($sformatf("v%0d.rx_count", i), 32'(rx_count), 32'(vt[i].e_rxc));
      chk($sformatf("v%0d.rx_empty", i), 32'(rx_empty), 32'(vt[i].e_rxe));
      chk($sformatf("v%0d.idle", i), 32'(idle), 32'(vt[i].e_idle));
      chk($sformatf("v%0d.spi_start", i), 32'(spi_start), 32'(vt[i].e_start));
      if (i < 3) begin
        chk($sformatf("v%0d.rd_data", i), 32'(rd_data), 32'h0);
        chk($sformatf("v%0d.rx_overflow", i), 32'(rx_overflow), 32'h0);
        chk($sformatf("v%0d.spi_tx_byte", i), 32'(spi_tx_byte), 32'h0);
      end
    end
    wr_en = 1'b0;
    chk("full.no_start", 32'(start_log.size()), 32'd0);

    // Drain the full TX FIFO: 0x10..0x17 in order, the 9th byte never sent.
    mm_mask = 8'h00;
    enable = 1'b1;
    wait_idle(300, "full.drain");
    chk("full.n_starts", 32'(start_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < start_log.size(); k++)
      chk($sformatf("full.start%0d", k), 32'(start_log[k]), 32'(8'h10 + k));
    chk("full.rx_count", 32'(rx_count), 32'd8);
    chk("full.tx_count", 32'(tx_count), 32'd0);
    chk("full.ovf0", 32'(rx_overflow), 32'd0);

    // RX full: one more transfer is dropped and sets the sticky flag.
    write_byte(8'h20);
    wait_idle(100, "ovf.xfer");
    chk("ovf.rx_count", 32'(rx_count), 32'd8);
    chk("ovf.flag", 32'(rx_overflow), 32'd1);
    @(negedge clk);
    chk("ovf.sticky", 32'(rx_overflow), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf.cleared", 32'(rx_overflow), 32'd0);

    // Done with rd_en in the same cycle: pop 0x10, push 0x21, no overflow.
    n = cyc;
    write_byte(8'h21);
    wait_to(n + 2 + mm_lat);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("ovf.rd_same.done_cyc", 32'(done_cyc[$]), 32'(n + 2 + mm_lat));
    chk("ovf.rd_same.count", 32'(rx_count), 32'd8);
    chk("ovf.rd_same.flag", 32'(rx_overflow), 32'd0);
    chk("ovf.rd_same.head", 32'(rd_data), 32'h11);

    // Drop coinciding with ovf_clr: the set wins.
    wait_idle(100, "ovf.idle2");
    n = cyc;
    write_byte(8'h22);
    wait_to(n + 2 + mm_lat);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf.set_wins", 32'(rx_overflow), 32'd1);
    chk("ovf.set_wins.count", 32'(rx_count), 32'd8);
    wait_idle(100, "ovf.idle3");
    for (int k = 0; k < 7; k++) read_check($sformatf("ovf.drain%0d", k), 8'(8'h11 + k));
    read_check("ovf.drain7", 8'h21);
    chk("ovf.drained", 32'(rx_empty), 32'd1);

    // Single byte: start at N+2, result visible at M+1, then popped.
    do_reset();
    mm_mask = 8'hFF;
    enable = 1'b1;
    n = cyc;
    write_byte(8'hA5);
    chk("one.tx_count", 32'(tx_count), 32'd1);
    wait_idle(100, "one.xfer");
    chk("one.n_starts", 32'(start_log.size()), 32'd1);
    if (start_log.size() > 0) begin
      chk("one.start_cyc", 32'(start_cyc[0]), 32'(n + 2));
      chk("one.tx_byte", 32'(start_log[0]), 32'hA5);
    end
    if (done_cyc.size() > 0) chk("one.done_lat", 32'(cyc), 32'(done_cyc[0] + 1 + GAPX));
    chk("one.rx_count", 32'(rx_count), 32'd1);
    read_check("one.rd_data", 8'h5A);
    chk("one.rx_empty", 32'(rx_empty), 32'd1);
    chk("one.rd_data0", 32'(rd_data), 32'h0);

    // Burst queued with enable low, then released.
    do_reset();
    mm_mask = 8'h00;
    for (int k = 1; k <= 4; k++) write_byte(8'(k));
    @(negedge clk);
    chk("burst.tx_count", 32'(tx_count), 32'd4);
    chk("burst.held", 32'(start_log.size()), 32'd0);
    chk("burst.idle_held", 32'(idle), 32'd0);
    enable = 1'b1;
    wait_idle(200, "burst.xfer");
    chk("burst.n_starts", 32'(start_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < start_log.size(); k++)
      chk($sformatf("burst.start%0d", k), 32'(start_log[k]), 32'(k + 1));
    if (start_cyc.size() > 1 && done_cyc.size() > 0)
      chk("burst.b2b", 32'(start_cyc[1] - done_cyc[0]), 32'(2 + GAPX));
    chk("burst.idle", 32'(idle), 32'd1);
    chk("burst.rx_count", 32'(rx_count), 32'd4);
    for (int k = 1; k <= 4; k++) read_check($sformatf("burst.rx%0d", k), 8'(k));
    chk("burst.rx_empty", 32'(rx_empty), 32'd1);

    // Gap spacing, then reset in WAIT_DONE followed by a stray done.
    do_reset();
    mm_mask = 8'h0F;
    write_byte(8'h31);
    write_byte(8'h32);
    enable = 1'b1;
    wait_idle(200, "gap.xfer");
    chk("gap.n_starts", 32'(start_log.size()), 32'd2);
    if (start_cyc.size() > 1 && done_cyc.size() > 0)
      chk("gap.spacing", 32'(start_cyc[1] - done_cyc[0]), 32'(2 + GAPX));
    chk("gap.rx_count", 32'(rx_count), 32'd2);

    mm_nochk = 1'b1;
    n = cyc;
    write_byte(8'h40);
    wait_to(n + 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.tx_byte", 32'(spi_tx_byte), 32'h0);
    chk("rstmid.rx_empty", 32'(rx_empty), 32'd1);
    chk("rstmid.idle", 32'(idle), 32'd1);
    wait_to(n + 2 + mm_lat + 2);
    chk("rstmid.stray_done", 32'(done_cyc[$]), 32'(n + 2 + mm_lat));
    chk("rstmid.rx_empty2", 32'(rx_empty), 32'd1);
    chk("rstmid.rx_count", 32'(rx_count), 32'd0);
    chk("rstmid.idle2", 32'(idle), 32'd1);
    chk("rstmid.no_relaunch", 32'(start_log.size()), 32'd3);
    chk("rstmid.ovf", 32'(rx_overflow), 32'd0);
    mm_nochk = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by 400000, expected earlier finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_xfer_queue.md
Name: spi_xfer_queue

Overview:
- Byte-stream front end for spi_master; sits directly upstream of it on the same system clock.
- Host pushes bytes into a TX FIFO.
- Block launches one master transfer per byte: one-cycle start pulse, tx_byte held stable.
- On each master done, captures the master's rx_byte into an RX FIFO for the host to drain, so multi-byte bursts run without per-byte host handshaking.

Parameters:
- DATA_WIDTH, 8, width of each SPI word; matches the spi_master DATA_WIDTH.
- DEPTH, 8, entries per FIFO (TX and RX); power of 2, >= 2.
- GAP_CYCLES, 4, idle clk cycles between a done and the next start (used only with SPI_QUEUE_GAP_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = drain TX FIFO into master; 0 = hold queued bytes.
- wr_en  in  1  push wr_data into TX FIFO.
- wr_data  in  DATA_WIDTH  byte to transmit.
- tx_full  out  1  TX FIFO full.
- tx_count  out  $clog2(DEPTH)+1  TX occupancy.
- rd_en  in  1  pop RX FIFO head.
- rd_data  out  DATA_WIDTH  RX FIFO head (first-word-fall-through).
- rx_empty  out  1  RX FIFO empty.
- rx_count  out  $clog2(DEPTH)+1  RX occupancy.
- rx_overflow  out  1  sticky: a received byte was dropped.
- ovf_clr  in  1  clears rx_overflow.
- idle  out  1  FSM in IDLE and TX FIFO empty.
- spi_start  out  1  to master start; one-cycle pulse.
- spi_tx_byte  out  DATA_WIDTH  to master tx_byte.
- spi_rx_byte  in  DATA_WIDTH  from master rx_byte.
- spi_busy  in  1  from master busy.
- spi_done  in  1  from master done; one-cycle pulse.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Both FIFOs emptied; FSM to IDLE.
  - spi_start=0, spi_tx_byte=0, rx_overflow=0.
  - tx_count=rx_count=0, tx_full=0, rx_empty=1, idle=1, rd_data=0.
  - Reset mid-transfer abandons the byte in flight; a later spi_done is ignored.
- TX FIFO:
  - wr_en with tx_full=1 is ignored; contents and count unchanged.
  - Write is visible in tx_count the next cycle.
  - No bypass path: a write into an empty FIFO cannot launch in the same cycle.
- FSM states IDLE, LAUNCH, WAIT_DONE, GAP:
  - IDLE: if enable & TX non-empty & !spi_busy, pop head into spi_tx_byte register and go to LAUNCH.
  - LAUNCH: spi_start=1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: spi_tx_byte held constant. On spi_done, push spi_rx_byte into RX FIFO, then go to GAP if the macro is defined, otherwise IDLE.
  - GAP: counter runs GAP_CYCLES cycles, then goes to IDLE.
- Latency:
  - wr_en at cycle N into an empty queue, with enable=1 and the master idle → spi_start high at cycle N+2.
  - spi_done at cycle M → rx_count updates and rd_data is valid at M+1.
  - Earliest next spi_start (no gap) is M+2.
- Enable deasserted mid-transfer: current transfer completes and its RX byte is captured; no further launch until enable=1.
- RX FIFO:
  - rd_en with rx_empty=1 is ignored.
  - Push while full: byte dropped, rx_overflow set.
  - Simultaneous push and rd_en while full: both happen, no overflow.
  - rx_overflow is cleared by ovf_clr the next cycle. If a drop and ovf_clr coincide, set wins.
- Pointers wrap modulo DEPTH. Count arithmetic is $clog2(DEPTH)+1 bits and never exceeds DEPTH.
- Byte order is preserved end to end.

Optional Feature:
- Macro SPI_QUEUE_GAP_EN.
- Defined: GAP state inserts exactly GAP_CYCLES idle cycles after each spi_done before IDLE may launch again. Provides chip-select deassert time for slaves.
- Undefined: GAP state and counter are not built; WAIT_DONE returns to IDLE directly and GAP_CYCLES has no effect.

Test Plan:
1. Reset → rst=1 for 3 cycles with wr_en=1 → tx_count=0, rx_empty=1, idle=1, spi_start never asserted.
2. Single byte → enable=1, write 0xA5; model master returns 0x5A on done → spi_start at N+2 with spi_tx_byte=0xA5, held until done; then rx_count=1, rd_data=0x5A; rd_en → rx_empty=1.
3. Burst with enable low → write 0x01..0x04 with enable=0 → no spi_start, tx_count=4. Then enable=1 → exactly four start pulses carrying 0x01..0x04 in order; RX returns the echoed bytes in order; idle=1 at the end.
4. TX full → DEPTH=8 with enable=0, write 9 bytes → tx_full=1, tx_count=8; 9th byte never transmitted.
5. RX overflow → fill RX to 8 and deliver another done → byte dropped, rx_overflow=1 until ovf_clr. Repeat with rd_en in the same cycle as done → no overflow, rx_count stays 8.
6. Gap and reset → with SPI_QUEUE_GAP_EN and GAP_CYCLES=3, two queued bytes → next start exactly 5 cycles after first done (M+5). Then rst during WAIT_DONE followed by a stray spi_done → RX stays empty, FSM IDLE.
